// File: rtl/alu_pkg.sv
// Shared opcode values and handshake state encoding for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_NAND = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_EQ   = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SRAV = 4'd9;
    localparam logic [3:0] OP_LUI  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;
    localparam logic [3:0] OP_SLL  = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, W cycles total.
// The product output is the accumulator value after the current iteration, so
// the parent can capture the final result in the same cycle that done is high.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter  int W   = 32,
    localparam int SHW = $clog2(W)
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int CNT_W = SHW + 1;

    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     acc;
    logic [W-1:0]     acc_next;
    logic [CNT_W-1:0] cnt;
    logic             last_iter;

    assign acc_next  = b_reg[0] ? (acc + a_reg) : acc;
    assign last_iter = (cnt == CNT_W'(W - 1));
    assign done      = busy && last_iter;
    assign product   = acc_next;

    // Latch operands on start, then add/shift once per cycle until W iterations are done.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            acc   <= acc_next;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt + 1'b1;
            if (last_iter) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU for the execute stage. Single-cycle ops return one cycle after
// acceptance; MUL hands off to the iterative multiplier and blocks new requests.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int W   = 32,
    localparam int SHW = $clog2(W)
) (
    input  logic           clk_i,
    input  logic           rst_n,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [3:0]     ctrl_i,
    input  logic [W-1:0]   src1_i,
    input  logic [W-1:0]   src2_i,
    input  logic [SHW-1:0] shamt_i,
    output logic [W-1:0]   result_o,
    output logic           zero_o,
    output logic           overflow_o,
    output logic           valid_o
);

    alu_state_t state;

    logic         accept;
    logic         mul_start;
    logic         mul_busy;
    logic         mul_done;
    logic [W-1:0] mul_product;
    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic [W-1:0] sra_res;
    logic [W-1:0] srav_res;
    logic [W-1:0] op_result;
    logic         op_ovf;

    assign accept    = valid_i && ready_o;
    assign mul_start = (state == ST_IDLE) && accept && (ctrl_i == OP_MUL);

    assign sum      = src1_i + src2_i;
    assign diff     = src1_i - src2_i;
    assign sra_res  = $signed(src2_i) >>> shamt_i;
    assign srav_res = $signed(src2_i) >>> src1_i[SHW-1:0];

    // The zero flag always follows whatever result is currently being presented.
    assign zero_o = (result_o == '0);

    alu_mul_seq #(.W(W)) u_mul (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (src1_i),
        .b       (src2_i),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Combinational result and overflow for every single-cycle opcode.
    always_comb begin
        op_result = '0;
        op_ovf    = 1'b0;
        case (ctrl_i)
            OP_AND:  op_result = src1_i & src2_i;
            OP_OR:   op_result = src1_i | src2_i;
            OP_NAND: op_result = ~(src1_i & src2_i);
            OP_NOR:  op_result = ~(src1_i | src2_i);
            OP_ADD: begin
                op_result = sum;
                op_ovf    = (src1_i[W-1] == src2_i[W-1]) && (sum[W-1] != src1_i[W-1]);
            end
            OP_SUB: begin
                op_result = diff;
                op_ovf    = (src1_i[W-1] != src2_i[W-1]) && (diff[W-1] != src1_i[W-1]);
            end
            OP_SLT:  op_result = {{(W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_EQ:   op_result = {{(W-1){1'b0}}, (src1_i == src2_i)};
            OP_SRA:  op_result = sra_res;
            OP_SRAV: op_result = srav_res;
            OP_LUI:  op_result = {src2_i[W/2-1:0], {(W/2){1'b0}}};
            OP_SLTU: op_result = {{(W-1){1'b0}}, (src1_i < src2_i)};
            OP_SLL:  op_result = src2_i << shamt_i;
            default: begin
                op_result = '0;
                op_ovf    = 1'b0;
            end
        endcase
    end

    // Handshake FSM: registers single-cycle results, or waits out the multiplier.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ready_o    <= 1'b1;
            valid_o    <= 1'b0;
            result_o   <= '0;
            overflow_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (ctrl_i == OP_MUL) begin
                            state   <= ST_MUL;
                            ready_o <= 1'b0;
                        end else begin
                            result_o   <= op_result;
                            overflow_o <= op_ovf;
                            valid_o    <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        result_o   <= mul_product;
                        overflow_o <= 1'b0;
                        valid_o    <= 1'b1;
                        ready_o    <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (!mul_busy) begin
                        ready_o <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    ready_o <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomised checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W   = 32;
    localparam int SHW = 5;

    logic           clk_i;
    logic           rst_n;
    logic           valid_i;
    logic           ready_o;
    logic [3:0]     ctrl_i;
    logic [W-1:0]   src1_i;
    logic [W-1:0]   src2_i;
    logic [SHW-1:0] shamt_i;
    logic [W-1:0]   result_o;
    logic           zero_o;
    logic           overflow_o;
    logic           valid_o;

    int errors = 0;
    int checks = 0;

    alu_seq #(.W(W)) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .ctrl_i     (ctrl_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .shamt_i    (shamt_i),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .overflow_o (overflow_o),
        .valid_o    (valid_o)
    );

    // Free-running clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: each op computed with wide integer arithmetic; returns {overflow, result}.
    function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [SHW-1:0] sh);
        longint      sa;
        longint      sb;
        longint      s;
        logic [63:0] wide;
        logic [W-1:0] lo;
        logic [W-1:0] res;
        logic         ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        ovf = 1'b0;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_NAND: res = ~(a & b);
            OP_NOR:  res = ~(a | b);
            OP_ADD, OP_SUB: begin
                s    = (op == OP_ADD) ? (sa + sb) : (sa - sb);
                wide = s;
                lo   = wide[W-1:0];
                res  = lo;
                ovf  = (longint'($signed(lo)) != s);
            end
            OP_SLT:  res = (sa < sb) ? 1 : 0;
            OP_SLTU: res = (longint'({32'b0, a}) < longint'({32'b0, b})) ? 1 : 0;
            OP_EQ:   res = (a == b) ? 1 : 0;
            OP_SRA: begin
                s    = sb >>> sh;
                wide = s;
                res  = wide[W-1:0];
            end
            OP_SRAV: begin
                s    = sb >>> a[SHW-1:0];
                wide = s;
                res  = wide[W-1:0];
            end
            OP_LUI: begin
                wide = {32'b0, b} * 64'd65536;
                res  = wide[W-1:0];
            end
            OP_SLL: begin
                wide = {32'b0, b} * (64'd1 << sh);
                res  = wide[W-1:0];
            end
            OP_MUL: begin
                wide = {32'b0, a} * {32'b0, b};
                res  = wide[W-1:0];
            end
            default: res = '0;
        endcase
        return {ovf, res};
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag, input logic [W-1:0] exp_res, input logic exp_ovf);
        checkOutput({tag, ".valid"}, W'(valid_o), W'(1'b1));
        checkOutput({tag, ".result"}, result_o, exp_res);
        checkOutput({tag, ".overflow"}, W'(overflow_o), W'(exp_ovf));
        checkOutput({tag, ".zero"}, W'(zero_o), W'(exp_res == '0));
    endtask

    // Present one request for one cycle; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [SHW-1:0] sh);
        ctrl_i  = op;
        src1_i  = a;
        src2_i  = b;
        shamt_i = sh;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic runSingle(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [SHW-1:0] sh);
        logic [W:0] m;
        m = model(op, a, b, sh);
        applyStimulus(op, a, b, sh);
        checkResult(tag, m[W-1:0], m[W]);
    endtask

    // Issue a MUL, poke a request while busy, and check timing and product.
    task automatic runMul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] m;
        int n;
        int pulses;
        m = model(OP_MUL, a, b, '0);
        applyStimulus(OP_MUL, a, b, '0);
        n = 0;
        pulses = 0;
        while (ready_o !== 1'b1 && n < 100) begin
            if (valid_o === 1'b1) pulses++;
            if (n == 5) begin
                ctrl_i  = OP_ADD;
                src1_i  = 32'd7;
                src2_i  = 32'd9;
                valid_i = 1'b1;
            end
            @(posedge clk_i);
            #1;
            valid_i = 1'b0;
            n++;
        end
        checkOutput({tag, ".busy_cycles"}, W'(n), W'(W));
        checkOutput({tag, ".early_valid"}, W'(pulses), '0);
        checkResult(tag, m[W-1:0], 1'b0);
        @(posedge clk_i);
        #1;
        checkOutput({tag, ".dropped_op"}, W'(valid_o), '0);
    endtask

    initial begin
        logic [W:0] m;
        int pulses;
        int r;
        logic [3:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] picks [5];

        rst_n   = 1'b0;
        valid_i = 1'b0;
        ctrl_i  = '0;
        src1_i  = '0;
        src2_i  = '0;
        shamt_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("reset.ready", W'(ready_o), W'(1'b1));
        checkOutput("reset.valid", W'(valid_o), '0);
        checkOutput("reset.result", result_o, '0);
        checkOutput("reset.zero", W'(zero_o), W'(1'b1));
        checkOutput("reset.overflow", W'(overflow_o), '0);

        runSingle("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, '0);
        checkOutput("add_ovf.value", result_o, 32'h8000_0000);
        checkOutput("add_ovf.flag", W'(overflow_o), W'(1'b1));
        @(posedge clk_i);
        #1;
        checkOutput("add_ovf.pulse_end", W'(valid_o), '0);
        runSingle("sub_zero", OP_SUB, 32'd5, 32'd5, '0);
        checkOutput("sub_zero.zero", W'(zero_o), W'(1'b1));

        runSingle("slt_ext", OP_SLT, 32'h8000_0000, 32'h1, '0);
        checkOutput("slt_ext.value", result_o, 32'h1);
        runSingle("sltu_ext", OP_SLTU, 32'h8000_0000, 32'h1, '0);
        checkOutput("sltu_ext.value", result_o, 32'h0);
        runSingle("slt_minmax", OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF, '0);
        runSingle("sltu_minmax", OP_SLTU, 32'h8000_0000, 32'h7FFF_FFFF, '0);
        runSingle("eq", OP_EQ, 32'h1234, 32'h1234, '0);
        checkOutput("eq.value", result_o, 32'h1);

        runSingle("sra", OP_SRA, '0, 32'h8000_0000, 5'd4);
        checkOutput("sra.value", result_o, 32'hF800_0000);
        runSingle("srav", OP_SRAV, 32'h25, 32'hF000_0000, '0);
        checkOutput("srav.value", result_o, 32'hFF80_0000);
        runSingle("sll", OP_SLL, '0, 32'h1, 5'd31);
        checkOutput("sll.value", result_o, 32'h8000_0000);
        runSingle("sll0", OP_SLL, '0, 32'hDEAD_BEEF, 5'd0);
        checkOutput("sll0.value", result_o, 32'hDEAD_BEEF);
        runSingle("lui", OP_LUI, '0, 32'hABCD, '0);
        checkOutput("lui.value", result_o, 32'hABCD_0000);

        runMul("mul", 32'hFFFF_FFFF, 32'd3);
        checkOutput("mul.value", result_o, 32'hFFFF_FFFD);

        runSingle("b2b_and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, '0);
        runSingle("b2b_or", OP_OR, 32'hF000_0000, 32'h0000_000F, '0);
        runSingle("b2b_nor", OP_NOR, 32'h0F0F_0000, 32'h0000_F0F0, '0);
        @(posedge clk_i);
        #1;
        checkOutput("b2b.pulse_end", W'(valid_o), '0);

        applyStimulus(OP_MUL, 32'd1000, 32'd1000, '0);
        repeat (9) begin
            @(posedge clk_i);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort.ready", W'(ready_o), W'(1'b1));
        checkOutput("abort.valid", W'(valid_o), '0);
        checkOutput("abort.zero", W'(zero_o), W'(1'b1));
        @(negedge clk_i);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (valid_o === 1'b1) pulses++;
        end
        checkOutput("abort.no_valid", W'(pulses), '0);
        runSingle("after_abort", OP_ADD, 32'd2, 32'd2, '0);
        checkOutput("after_abort.value", result_o, 32'd4);

        runSingle("illegal15", 4'd15, 32'hFFFF_FFFF, 32'h1234_5678, 5'd3);
        checkOutput("illegal15.zero", W'(zero_o), W'(1'b1));
        runSingle("illegal14", 4'd14, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd1);

        picks[0] = 32'h0;
        picks[1] = 32'h8000_0000;
        picks[2] = 32'h7FFF_FFFF;
        picks[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < 200; i++) begin
            r  = $urandom_range(0, 14);
            op = (r >= 13) ? 4'(r + 1) : 4'(r);
            picks[4] = $urandom;
            a = picks[$urandom_range(0, 4)];
            picks[4] = $urandom;
            b = picks[$urandom_range(0, 4)];
            runSingle($sformatf("rand%0d_op%0d", i, op), op, a, b, 5'($urandom_range(0, 31)));
        end
        for (int i = 0; i < 4; i++) begin
            runMul($sformatf("randmul%0d", i), $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
